// File: rtl/msrv32_pc_pkg.sv
// rtl/msrv32_pc_pkg.sv - shared state, pc_src and redirect-priority encodings
// for the registered msrv32 program-counter generator.
package msrv32_pc_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STALL = 2'b10
   } pc_state_t;

   localparam logic [1:0] PC_BOOT     = 2'b00;
   localparam logic [1:0] PC_TRAP_RET = 2'b01;
   localparam logic [1:0] PC_TRAP     = 2'b10;
   localparam logic [1:0] PC_OPER     = 2'b11;

   // Larger value wins when two redirects compete for the pending slot.
   localparam logic [1:0] PRIO_NONE   = 2'd0;
   localparam logic [1:0] PRIO_BRANCH = 2'd1;
   localparam logic [1:0] PRIO_RETURN = 2'd2;
   localparam logic [1:0] PRIO_TRAP   = 2'd3;

endpackage

// File: rtl/msrv32_pc_gen_if.sv
// rtl/msrv32_pc_gen_if.sv - instruction-fetch request bus between the PC
// generator (master) and the AHB instruction port (slave).
interface msrv32_pc_gen_if #(
   parameter int XLEN = 32
);
   logic            ahb_ready_in;
   logic [XLEN-1:0] i_addr_out;
   logic            fetch_valid_out;

   modport master (input ahb_ready_in, output i_addr_out, output fetch_valid_out);
   modport slave  (output ahb_ready_in, input i_addr_out, input fetch_valid_out);
endinterface

// File: rtl/msrv32_pc_redirect_buf.sv
// rtl/msrv32_pc_redirect_buf.sv - holds one redirect that arrived while the
// instruction port was stalled; a newer redirect replaces it only at equal or higher priority.
module msrv32_pc_redirect_buf
   import msrv32_pc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            capture_en,
   input  logic            clear,
   input  logic [1:0]      in_prio,
   input  logic [XLEN-1:0] in_addr,
   output logic [XLEN-1:0] pend_addr,
   output logic [1:0]      pend_prio,
   output logic            pending
);

   logic [XLEN-1:0] addr_q;
   logic [1:0]      prio_q;
   logic            overwrite;

   assign overwrite = capture_en && (in_prio != PRIO_NONE) && (in_prio >= prio_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         prio_q <= PRIO_NONE;
      end else if (clear) begin
         addr_q <= '0;
         prio_q <= PRIO_NONE;
      end else if (overwrite) begin
         addr_q <= in_addr;
         prio_q <= in_prio;
      end
   end

   assign pend_addr = addr_q;
   assign pend_prio = prio_q;
   assign pending   = (prio_q != PRIO_NONE);

endmodule

// File: rtl/msrv32_pc_gen.sv
// rtl/msrv32_pc_gen.sv - registered PC / fetch-address generator with stall-safe
// redirect capture; define MSRV32_PC_COMPRESSED_EN for 16-bit instruction support.
module msrv32_pc_gen
   import msrv32_pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] BOOT_ADDRESS = '0
) (
   input  logic                  ms_riscv32_mp_clk_in,
   input  logic                  ms_riscv32_mp_rst_in,
   msrv32_pc_gen_if.master       fetch_bus,
   input  logic [1:0]            pc_src_in,
   input  logic                  branch_taken_in,
   input  logic [XLEN-1:0]       target_in,
   input  logic [XLEN-1:0]       epc_in,
   input  logic [XLEN-1:0]       trap_address_in,
   input  logic                  instr_16_in,
   output logic [XLEN-1:0]       pc_out,
   output logic [XLEN-1:0]       pc_plus_4_out,
   output logic                  misaligned_instr_out,
   output logic                  redirect_pending_out
);

   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   pc_state_t       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            valid_q;
   logic [XLEN-1:0] len;
   logic [XLEN-1:0] target_even;
   logic [1:0]      in_prio;
   logic [XLEN-1:0] in_addr;
   logic            capture_en, clear;
   logic [XLEN-1:0] pend_addr;
   logic [1:0]      pend_prio;
   logic            pending;
   logic [1:0]      unused_bits;

`ifdef MSRV32_PC_COMPRESSED_EN
   assign len                  = instr_16_in ? XLEN'(2) : FOUR;
   assign misaligned_instr_out = 1'b0;
   assign unused_bits          = {target_in[0], 1'b0};
`else
   assign len                  = FOUR;
   assign misaligned_instr_out = branch_taken_in && (pc_src_in == PC_OPER) && target_in[1];
   assign unused_bits          = {target_in[0], instr_16_in};
`endif

   assign target_even = {target_in[XLEN-1:1], 1'b0};

   always_comb begin
      in_prio = PRIO_NONE;
      in_addr = target_even;
      case (pc_src_in)
         PC_TRAP: begin
            in_prio = PRIO_TRAP;
            in_addr = trap_address_in;
         end
         PC_TRAP_RET: begin
            in_prio = PRIO_RETURN;
            in_addr = epc_in;
         end
         PC_OPER: begin
            if (branch_taken_in && !misaligned_instr_out) in_prio = PRIO_BRANCH;
         end
         default: ;
      endcase
   end

   // Fetch runs one instruction ahead of execute after boot, so the
   // sequential step advances both registers independently.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      capture_en = 1'b0;
      clear      = 1'b0;
      case (state_q)
         ST_BOOT: begin
            if (valid_q && fetch_bus.ahb_ready_in) begin
               pc_d    = BOOT_ADDRESS;
               addr_d  = BOOT_ADDRESS + FOUR;
               state_d = ST_RUN;
            end
         end
         ST_RUN, ST_STALL: begin
            if (fetch_bus.ahb_ready_in) begin
               state_d = ST_RUN;
               clear   = 1'b1;
               if (in_prio == PRIO_TRAP) begin
                  pc_d   = trap_address_in;
                  addr_d = trap_address_in;
               end else if (pending) begin
                  pc_d   = pend_addr;
                  addr_d = pend_addr;
               end else if (in_prio != PRIO_NONE) begin
                  pc_d   = in_addr;
                  addr_d = in_addr;
               end else if ((pc_src_in == PC_OPER) && !misaligned_instr_out) begin
                  pc_d   = pc_q + len;
                  addr_d = addr_q + len;
               end
            end else begin
               state_d    = ST_STALL;
               capture_en = 1'b1;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         state_q <= ST_BOOT;
         pc_q    <= BOOT_ADDRESS;
         addr_q  <= BOOT_ADDRESS;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         valid_q <= 1'b1;
      end
   end

   msrv32_pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
      .clk        (ms_riscv32_mp_clk_in),
      .rst        (ms_riscv32_mp_rst_in),
      .capture_en (capture_en),
      .clear      (clear),
      .in_prio    (in_prio),
      .in_addr    (in_addr),
      .pend_addr  (pend_addr),
      .pend_prio  (pend_prio),
      .pending    (pending)
   );

   logic [1:0] unused_prio;
   assign unused_prio = pend_prio & unused_bits;

   assign fetch_bus.i_addr_out      = addr_q;
   assign fetch_bus.fetch_valid_out = valid_q;
   assign pc_out                    = pc_q;
   assign pc_plus_4_out             = pc_q + len;
   assign redirect_pending_out      = pending;

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// tb/tb_msrv32_pc_gen.sv - scoreboard bench for msrv32_pc_gen with directed and random stimulus.
module tb_msrv32_pc_gen;

   localparam int          XLEN = 32;
   localparam logic [31:0] BOOT = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  pc_src;
   logic        br;
   logic [31:0] tgt, epc, trp;
   logic        i16;
   logic [31:0] pc, pc4;
   logic        mis, pend;

   always #5 clk = ~clk;

   msrv32_pc_gen_if #(.XLEN(XLEN)) fbus ();

   msrv32_pc_gen #(.XLEN(XLEN), .BOOT_ADDRESS(BOOT)) dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .fetch_bus            (fbus),
      .pc_src_in            (pc_src),
      .branch_taken_in      (br),
      .target_in            (tgt),
      .epc_in               (epc),
      .trap_address_in      (trp),
      .instr_16_in          (i16),
      .pc_out               (pc),
      .pc_plus_4_out        (pc4),
      .misaligned_instr_out (mis),
      .redirect_pending_out (pend)
   );

   typedef struct {
      int          step;
      logic [31:0] pc, fa, plus4;
      logic        valid, pend, mis;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   step   = 0;

   // Reference model: architectural state after the most recent clock edge.
   bit          m_valid, m_booted;
   logic [31:0] m_pc, m_fa, m_pend;
   int          m_rank;

   function automatic logic [31:0] m_len(input bit b16);
`ifdef MSRV32_PC_COMPRESSED_EN
      return b16 ? 32'd2 : 32'd4;
`else
      return 32'd4;
`endif
   endfunction

   function automatic bit m_mis(input logic [1:0] s, input bit b, input logic [31:0] t);
`ifdef MSRV32_PC_COMPRESSED_EN
      return 1'b0;
`else
      return (s == 2'b11) && b && t[1];
`endif
   endfunction

   function automatic void model_reset();
      m_valid = 0; m_booted = 0; m_pc = BOOT; m_fa = BOOT; m_pend = '0; m_rank = 0;
   endfunction

   function automatic void model_step(input bit rdy, input logic [1:0] s, input bit b,
                                      input logic [31:0] t, e, tr, input bit b16);
      int          rank;
      logic [31:0] dest;
      bit          mi;
      mi   = m_mis(s, b, t);
      rank = 0;
      dest = {t[31:1], 1'b0};
      if (s == 2'b10) begin rank = 3; dest = tr; end
      else if (s == 2'b01) begin rank = 2; dest = e; end
      else if (s == 2'b11 && b && !mi) rank = 1;
      if (!m_valid) m_valid = 1;
      else if (!m_booted) begin
         if (rdy) begin m_pc = BOOT; m_fa = BOOT + 4; m_booted = 1; end
      end else if (rdy) begin
         if (rank == 3)      begin m_pc = tr; m_fa = tr; end
         else if (m_rank)    begin m_pc = m_pend; m_fa = m_pend; end
         else if (rank != 0) begin m_pc = dest; m_fa = dest; end
         else if (s == 2'b11 && !mi) begin
            m_pc = m_pc + m_len(b16);
            m_fa = m_fa + m_len(b16);
         end
         m_rank = 0;
      end else if (rank != 0 && rank >= m_rank) begin
         m_rank = rank; m_pend = dest;
      end
   endfunction

   task automatic drive(input bit r, input bit rdy, input logic [1:0] s, input bit b,
                        input logic [31:0] t, input logic [31:0] e = 32'h0,
                        input logic [31:0] tr = 32'h0, input bit b16 = 1'b0);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r; fbus.ahb_ready_in = rdy; pc_src = s; br = b; tgt = t; epc = e; trp = tr; i16 = b16;
      if (r) model_reset();
      step++;
      x.step = step; x.pc = m_pc; x.fa = m_fa; x.valid = m_valid;
      x.pend = (m_rank != 0); x.plus4 = m_pc + m_len(b16); x.mis = m_mis(s, b, t);
      q.push_back(x);
      if (!r) model_step(rdy, s, b, t, e, tr, b16);
   endtask

   task automatic chk(input string name, input int st, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h, expected %h", name, st, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t x;
         x = q.pop_front();
         chk("i_addr", x.step, fbus.i_addr_out, x.fa);
         chk("fetch_valid", x.step, 32'(fbus.fetch_valid_out), 32'(x.valid));
         chk("pc", x.step, pc, x.pc);
         chk("pc_plus_4", x.step, pc4, x.plus4);
         chk("misaligned", x.step, 32'(mis), 32'(x.mis));
         chk("pending", x.step, 32'(pend), 32'(x.pend));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; fbus.ahb_ready_in = 1'b0; pc_src = 2'b00; br = 0;
      tgt = '0; epc = '0; trp = '0; i16 = 0;
      model_reset();
      drive(1, 1, 2'b11, 0, 0);
      drive(1, 1, 2'b11, 0, 0);
      // boot and sequential fetch
      repeat (5) drive(0, 1, 2'b11, 0, 0);
      // branch to 0x100, misaligned 0x202, aligned 0x200
      drive(0, 1, 2'b11, 1, 32'h100);
      drive(0, 1, 2'b11, 1, 32'h202);
      drive(0, 1, 2'b11, 1, 32'h200);
      drive(0, 1, 2'b11, 0, 0);
      // stall: branch then trap, trap wins on ready
      drive(0, 0, 2'b11, 1, 32'h400);
      drive(0, 0, 2'b10, 0, 0, 0, 32'h80);
      drive(0, 0, 2'b11, 0, 0);
      drive(0, 1, 2'b11, 0, 0);
      drive(0, 1, 2'b11, 0, 0);
      // stall: trap then branch, branch must not overwrite
      drive(0, 0, 2'b10, 0, 0, 0, 32'h80);
      drive(0, 0, 2'b11, 1, 32'h400);
      drive(0, 1, 2'b11, 0, 0);
      // stall: return then branch, then return applied
      drive(0, 0, 2'b01, 0, 0, 32'h300);
      drive(0, 0, 2'b11, 1, 32'h500);
      drive(0, 1, 2'b00, 0, 0);
      // pending applied while new trap arrives on ready
      drive(0, 0, 2'b11, 1, 32'h600);
      drive(0, 1, 2'b10, 0, 0, 0, 32'h44);
      // hold with pc_src 00
      drive(0, 1, 2'b00, 0, 0);
      drive(0, 1, 2'b00, 0, 0);
      // address wrap
      drive(0, 1, 2'b11, 1, 32'hFFFF_FFFD);
      repeat (3) drive(0, 1, 2'b11, 0, 0);
      // reset mid-stall discards pending redirect
      drive(0, 0, 2'b10, 0, 0, 0, 32'h90);
      drive(1, 0, 2'b11, 0, 0);
      drive(0, 1, 2'b11, 0, 0);
      repeat (3) drive(0, 1, 2'b11, 0, 0);
      // random traffic
      for (int i = 0; i < 2000; i++) begin
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      drive(0, 1, 2'b11, 0, 0);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/msrv32_pc_gen.md
Name: msrv32_pc_gen

Overview:
- Parametrised, registered successor to the msrv32 program-counter mux.
- Holds the architectural PC and the fetch address in flops.
- Selects the next PC by priority: trap_taken > trap_return > branch > sequential.
- Remembers a redirect that arrives while the AHB instruction port is stalled, so it is applied once the port is ready again. Sits between the control/CSR unit and the instruction-fetch AHB master.

Parameters:
- XLEN, 32, datapath/address width.
- BOOT_ADDRESS, 32'h0000_0000, first fetch address after reset (XLEN wide).

Ports:
- ms_riscv32_mp_clk_in  input  1  system clock, rising edge.
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset.
- ahb_ready_in  input  1  instruction port accepts i_addr_out this cycle.
- pc_src_in  input  2  00 hold/boot, 01 trap_return, 10 trap_taken, 11 operate.
- branch_taken_in  input  1  branch/jump resolved taken (used only when pc_src_in=11).
- target_in  input  XLEN  branch/jump target; bit0 is ignored (treated as 0).
- epc_in  input  XLEN  return address for trap_return.
- trap_address_in  input  XLEN  trap vector.
- instr_16_in  input  1  current instruction is 16-bit (ignored unless the optional feature is compiled in).
- i_addr_out  output  XLEN  registered fetch address.
- fetch_valid_out  output  1  i_addr_out is a valid request.
- pc_out  output  XLEN  registered PC of the instruction in execute.
- pc_plus_4_out  output  XLEN  pc_out + instruction length (link value).
- misaligned_instr_out  output  1  the taken branch target is misaligned (combinational).
- redirect_pending_out  output  1  a redirect is captured and waiting.

Behaviour:
- Reset, asynchronous: state=BOOT; i_addr_out=BOOT_ADDRESS; pc_out=BOOT_ADDRESS; fetch_valid_out=0; redirect_pending_out=0; pending register cleared.
- States BOOT, RUN, STALL; 2-bit encoding, defined in the package.
- BOOT: fetch_valid_out=1, i_addr_out=BOOT_ADDRESS. On ahb_ready_in=1: pc_out<=BOOT_ADDRESS, i_addr_out<=BOOT_ADDRESS+4, go to RUN.
- next_pc priority:
  - pc_src 10 -> trap_address_in
  - 01 -> epc_in
  - 11 with branch_taken_in -> {target_in[XLEN-1:1],1'b0}
  - otherwise -> pc_out+len, where len=4 by default.
  - pc_src 00 in RUN holds pc_out (no advance).
- RUN with ahb_ready_in=1:
  - If redirect_pending_out=1, the pending address is used instead of next_pc; a new trap in the same cycle overrides it.
  - pc_out<=next_pc; i_addr_out<=next_pc; the pending register is cleared.
  - Latency is one cycle from redirect input to i_addr_out.
- RUN with ahb_ready_in=0: go to STALL; pc_out and i_addr_out hold.
- STALL: i_addr_out, pc_out and fetch_valid_out=1 are stable (AHB address-hold rule).
  - Any redirect that cycle is written into the pending register if its priority is greater than or equal to the stored one. Priority codes: trap=3, return=2, branch=1, none=0.
  - redirect_pending_out=1 from the next cycle.
  - Sequential advance is never captured.
  - On ahb_ready_in=1: behave as RUN with ready and return to RUN.
- misaligned_instr_out = branch_taken_in & pc_src_in==11 & target_in[1]. When it is asserted, the target is still not loaded: pc_out/i_addr_out hold, and the control unit raises the trap on the following cycle.
- Address arithmetic is modulo 2^XLEN: 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no flag.
- Reset asserted mid-stall discards the pending redirect.

Optional Feature:
- Macro MSRV32_PC_COMPRESSED_EN.
- When defined:
  - len = instr_16_in ? 2 : 4.
  - misaligned_instr_out is tied to 0.
  - pc_plus_4_out is pc_out+len.
- When undefined: instr_16_in is unused, len=4, and misaligned detection works as described in Behaviour.

Decomposition:
- Package msrv32_pc_pkg holds:
  - state localparams (BOOT/RUN/STALL);
  - pc_src codes (PC_BOOT=00, PC_TRAP_RET=01, PC_TRAP=10, PC_OPER=11);
  - redirect priority codes.
- One sub-module, msrv32_pc_redirect_buf: the pending address register, its priority register and the overwrite compare.

Test Plan:
- Reset release, ahb_ready_in=1, pc_src=11, no branch -> i_addr_out 0x0, 0x4, 0x8 on successive cycles; pc_out lags one cycle.
- RUN at pc 0x100, branch_taken_in=1, target 0x200 -> next cycle pc_out=0x200 and i_addr_out=0x200; target 0x202 -> misaligned_instr_out=1 and pc holds 0x100.
- ready=0 for 3 cycles, branch to 0x400 in cycle 1, trap to 0x80 in cycle 2 -> redirect_pending_out=1 and i_addr_out stable; on ready, pc_out=0x80.
- Stall with a pending trap 0x80, then a branch in the next stall cycle -> the branch does not overwrite; 0x80 is applied.
- pc_out=0xFFFF_FFFC sequential -> 0x0000_0000; pc_plus_4_out=0x0.
- With MSRV32_PC_COMPRESSED_EN, instr_16_in=1 at pc 0x10 -> pc_out 0x12, pc_plus_4_out 0x12; target 0x202 taken -> loads 0x202, misaligned=0.
